// File: rtl/ysyx_25020047_lsu.sv
// ysyx_25020047_lsu: load/store unit between execute and register writeback.
// One memory transaction per instruction over a valid/ready request bus and an
// always-accepted response bus; non-memory results pass through in one cycle.
// Optional feature macro: LSU_MISALIGN_EN. When defined, half/word accesses that
// cross a word boundary are split into two word transactions (low word first)
// instead of faulting. Misaligned half accesses that stay inside one word are
// served by a single transaction.
//
// state | meaning
// IDLE  | ready for a new execute result
// REQ   | request presented, waiting for mem_req_ready
// RESP  | waiting for response, timeout counter running
// REQ2  | (LSU_MISALIGN_EN) high-word request of a split access
// RESP2 | (LSU_MISALIGN_EN) high-word response of a split access
// DONE  | writeback presented, held until out_ready
module ysyx_25020047_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] RESET_ADDR     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_read,
    input  logic        in_write,
    input  logic [1:0]  in_size,
    input  logic        in_unsigned,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    input  logic        in_wen,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_wen,
    output logic        out_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wmask,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata,
    input  logic        mem_rsp_err
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
`ifdef LSU_MISALIGN_EN
        S_REQ2,
        S_RESP2,
`endif
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        read_q, read_d;
    logic        wen_q, wen_d;
    logic [31:0] out_data_q, out_data_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic        out_wen_q, out_wen_d;
    logic        out_err_q, out_err_d;
    logic        req_wen_q, req_wen_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [3:0]  req_wmask_q, req_wmask_d;
`ifdef LSU_MISALIGN_EN
    logic        cross_q, cross_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] wdata_hi_q, wdata_hi_d;
    logic [3:0]  wmask_hi_q, wmask_hi_d;
    logic [7:0]  wide_wmask;
    logic [63:0] wide_wdata;
    logic        in_cross;
`endif

    logic        in_fault;
    logic [3:0]  base_mask;
    logic [3:0]  lane_wmask;
    logic [31:0] lane_wdata;
    logic [31:0] rsp_word;
    logic        timed_out;
    logic [31:0] fin_data;
    logic        fin_wen;

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] size,
                                           input logic uns);
        logic [31:0] r;
        case (size)
            2'd0:    r = {{24{w[7] & ~uns}}, w[7:0]};
            2'd1:    r = {{16{w[15] & ~uns}}, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    // Access legality check and store byte-lane placement from the incoming op.
    always_comb begin
        in_fault = (in_read & in_write) | (in_size == 2'd3);
`ifndef LSU_MISALIGN_EN
        if (in_size == 2'd1 && in_addr[0]) in_fault = 1'b1;
        if (in_size == 2'd2 && in_addr[1:0] != 2'b00) in_fault = 1'b1;
`endif
        base_mask  = 4'hF;
        lane_wdata = in_wdata;
        case (in_size)
            2'd0: begin
                base_mask  = 4'b0001;
                lane_wdata = {4{in_wdata[7:0]}};
            end
            2'd1: begin
                base_mask  = 4'b0011;
                lane_wdata = {2{in_wdata[15:0]}};
            end
            default: ;
        endcase
        lane_wmask = base_mask << in_addr[1:0];
`ifdef LSU_MISALIGN_EN
        wide_wmask = {4'h0, base_mask} << in_addr[1:0];
        wide_wdata = {32'h0, in_wdata} << {in_addr[1:0], 3'b000};
        in_cross   = (in_size == 2'd1 && in_addr[1:0] == 2'b11) ||
                     (in_size == 2'd2 && in_addr[1:0] != 2'b00);
`endif
    end

    // Response alignment and the writeback value produced when a response lands.
    always_comb begin
        rsp_word = mem_rsp_rdata >> {off_q, 3'b000};
`ifdef LSU_MISALIGN_EN
        if (state_q == S_RESP2) rsp_word = 32'({mem_rsp_rdata, lo_q} >> {off_q, 3'b000});
`endif
        fin_wen   = read_q & wen_q & ~mem_rsp_err;
        fin_data  = (read_q && !mem_rsp_err) ? extend(rsp_word, size_q, uns_q) : 32'h0;
        timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        read_d      = read_q;
        wen_d       = wen_q;
        out_data_d  = out_data_q;
        out_rd_d    = out_rd_q;
        out_wen_d   = out_wen_q;
        out_err_d   = out_err_q;
        req_wen_d   = req_wen_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_wmask_d = req_wmask_q;
`ifdef LSU_MISALIGN_EN
        cross_d     = cross_q;
        lo_d        = lo_q;
        wdata_hi_d  = wdata_hi_q;
        wmask_hi_d  = wmask_hi_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    off_d     = in_addr[1:0];
                    size_d    = in_size;
                    uns_d     = in_unsigned;
                    read_d    = in_read;
                    wen_d     = in_wen;
                    out_rd_d  = in_rd;
                    out_err_d = 1'b0;
                    if (!in_read && !in_write) begin
                        state_d    = S_DONE;
                        out_data_d = in_addr;
                        out_wen_d  = in_wen;
                    end else if (in_fault) begin
                        state_d    = S_DONE;
                        out_data_d = 32'h0;
                        out_wen_d  = 1'b0;
                        out_err_d  = 1'b1;
                    end else begin
                        state_d     = S_REQ;
                        req_wen_d   = in_write;
                        req_addr_d  = {in_addr[31:2], 2'b00};
                        req_wdata_d = in_write ? lane_wdata : 32'h0;
                        req_wmask_d = in_write ? lane_wmask : 4'h0;
`ifdef LSU_MISALIGN_EN
                        cross_d    = in_cross;
                        wdata_hi_d = 32'h0;
                        wmask_hi_d = 4'h0;
                        if (in_cross && in_write) begin
                            req_wdata_d = wide_wdata[31:0];
                            req_wmask_d = wide_wmask[3:0];
                            wdata_hi_d  = wide_wdata[63:32];
                            wmask_hi_d  = wide_wmask[7:4];
                        end
`endif
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_RESP;
                    cnt_d   = '0;
                end
            end
            S_RESP: begin
                if (mem_rsp_valid) begin
`ifdef LSU_MISALIGN_EN
                    if (cross_q && !mem_rsp_err) begin
                        state_d     = S_REQ2;
                        lo_d        = mem_rsp_rdata;
                        req_addr_d  = req_addr_q + 32'd4;
                        req_wdata_d = wdata_hi_q;
                        req_wmask_d = wmask_hi_q;
                    end else
`endif
                    begin
                        state_d    = S_DONE;
                        out_data_d = fin_data;
                        out_wen_d  = fin_wen;
                        out_err_d  = mem_rsp_err;
                    end
                end else if (timed_out) begin
                    state_d    = S_DONE;
                    out_data_d = 32'h0;
                    out_wen_d  = 1'b0;
                    out_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef LSU_MISALIGN_EN
            S_REQ2: begin
                if (mem_req_ready) begin
                    state_d = S_RESP2;
                    cnt_d   = '0;
                end
            end
            S_RESP2: begin
                if (mem_rsp_valid) begin
                    state_d    = S_DONE;
                    out_data_d = fin_data;
                    out_wen_d  = fin_wen;
                    out_err_d  = mem_rsp_err;
                end else if (timed_out) begin
                    state_d    = S_DONE;
                    out_data_d = 32'h0;
                    out_wen_d  = 1'b0;
                    out_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    req_wen_d   = 1'b0;
                    req_addr_d  = RESET_ADDR;
                    req_wdata_d = 32'h0;
                    req_wmask_d = 4'h0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            read_q      <= 1'b0;
            wen_q       <= 1'b0;
            out_data_q  <= 32'h0;
            out_rd_q    <= 5'd0;
            out_wen_q   <= 1'b0;
            out_err_q   <= 1'b0;
            req_wen_q   <= 1'b0;
            req_addr_q  <= RESET_ADDR;
            req_wdata_q <= 32'h0;
            req_wmask_q <= 4'h0;
`ifdef LSU_MISALIGN_EN
            cross_q     <= 1'b0;
            lo_q        <= 32'h0;
            wdata_hi_q  <= 32'h0;
            wmask_hi_q  <= 4'h0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            read_q      <= read_d;
            wen_q       <= wen_d;
            out_data_q  <= out_data_d;
            out_rd_q    <= out_rd_d;
            out_wen_q   <= out_wen_d;
            out_err_q   <= out_err_d;
            req_wen_q   <= req_wen_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_wmask_q <= req_wmask_d;
`ifdef LSU_MISALIGN_EN
            cross_q     <= cross_d;
            lo_q        <= lo_d;
            wdata_hi_q  <= wdata_hi_d;
            wmask_hi_q  <= wmask_hi_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
`ifdef LSU_MISALIGN_EN
    assign mem_req_valid = (state_q == S_REQ) || (state_q == S_REQ2);
`else
    assign mem_req_valid = (state_q == S_REQ);
`endif
    assign out_data      = out_data_q;
    assign out_rd        = out_rd_q;
    assign out_wen       = out_wen_q;
    assign out_err       = out_err_q;
    assign mem_req_wen   = req_wen_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wdata = req_wdata_q;
    assign mem_req_wmask = req_wmask_q;

endmodule

// File: doc/ysyx_25020047_lsu.md
Name: ysyx_25020047_lsu

Overview:
Load/store unit directly downstream of the execute stage. Consumes the execute result (effective address or ALU value), the read/write flags and the store data. Performs one memory transaction per instruction over a valid/ready request and response bus. Returns the aligned, extended writeback value to the register-writeback stage. Non-memory instructions pass through with one cycle of latency.

Parameters:
TIMEOUT_CYCLES, 255, max cycles waiting for mem_rsp_valid before error; 0 disables the timeout counter.
RESET_ADDR, 32'h0, value of mem_req_addr while idle/reset.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  execute result valid
in_ready  out  1  LSU can accept; high only in IDLE
in_read  in  1  load instruction
in_write  in  1  store instruction
in_size  in  2  0=byte, 1=half, 2=word; 3 illegal
in_unsigned  in  1  zero-extend load (lbu/lhu)
in_addr  in  32  effective address or ALU result
in_wdata  in  32  store data (rdata2)
in_rd  in  5  destination register
in_wen  in  1  register write enable from execute
out_valid  out  1  writeback valid
out_ready  in  1  writeback accepts
out_data  out  32  writeback value
out_rd  out  5  destination register
out_wen  out  1  register write enable (forced 0 on error)
out_err  out  1  access fault: misaligned, illegal size, read&write, bus error, timeout
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_wen  out  1  1=store
mem_req_addr  out  32  word-aligned address (in_addr & ~3)
mem_req_wdata  out  32  store data shifted to byte lane
mem_req_wmask  out  4  byte strobes
mem_rsp_valid  in  1  response valid (always accepted)
mem_rsp_rdata  in  32  load data, full word
mem_rsp_err  in  1  bus error with response

Behaviour:
- Reset: state=IDLE; in_ready=1, out_valid=0, out_data=0, out_rd=0, out_wen=0, out_err=0, mem_req_valid=0, mem_req_wen=0, mem_req_addr=RESET_ADDR, mem_req_wdata=0, mem_req_wmask=0, timeout counter=0. Reset mid-transaction aborts it; later mem_rsp_valid pulses are ignored while IDLE.
- FSM: IDLE, REQ, RESP, DONE.
- IDLE: on in_valid (in_ready=1) latch all inputs.
  - Neither read nor write: go to DONE; out_data=in_addr, out_wen=in_wen. Latency is 1 cycle.
  - Any fault check fails: go to DONE with out_err=1, out_wen=0, no bus activity. Fault checks: read&write both set; in_size=3; half with addr[0]=1; word with addr[1:0]!=0.
  - Otherwise: go to REQ.
- REQ: mem_req_valid=1, with all request fields stable until the handshake.
  - Handshake (mem_req_valid & mem_req_ready): go to RESP.
- RESP: counter increments each cycle.
  - On mem_rsp_valid: go to DONE.
  - Load: out_data = selected byte/half at addr[1:0], sign- or zero-extended. Word loads pass unchanged.
  - Store: out_wen=0, out_data=0.
  - mem_rsp_err=1: out_err=1, out_wen=0.
  - Timeout: counter reaches TIMEOUT_CYCLES (when nonzero) without a response: go to DONE with out_err=1.
- Store lanes:
  - Byte: wmask=1<<addr[1:0], wdata=byte replicated x4.
  - Half: wmask=4'b0011<<addr[1:0], wdata=half replicated x2.
  - Word: wmask=4'hF.
  - Loads use wmask=0.
- DONE: out_valid=1, outputs held stable until out_ready. Handshake: go to IDLE, out_valid=0.
- No new request is accepted until DONE completes; there is exactly one outstanding transaction.
- A response arriving in the same cycle as the request handshake is not legal bus behaviour; the bench must not generate it.

Optional Feature:
LSU_MISALIGN_EN:
- Defined: misaligned half/word accesses are split into two sequential word transactions. Extra states are REQ2 and RESP2; the low word is accessed first and the bytes are merged. out_err is raised only for size=3, read&write, bus error or timeout.
- Undefined: misaligned accesses fault as above, with no bus activity.

Test Plan:
- Pass-through: in_addr=32'h1234, read=write=0, in_wen=1, rd=5 -> out_valid next cycle, out_data=32'h1234, out_wen=1, mem_req_valid never high.
- lbu/lb: addr=32'h8000_0003, rsp_rdata=32'h80AA_BBCC:
  - unsigned -> out_data=32'h0000_0080.
  - signed -> out_data=32'hFFFF_FF80.
  - mem_req_addr=32'h8000_0000.
- sb: addr=32'h8000_0002, wdata=32'h0000_00A5 -> wmask=4'b0100, wdata=32'hA5A5_A5A5, out_wen=0. Hold mem_req_ready low 3 cycles -> request fields stable.
- Misaligned lw: addr=32'h8000_0001 with macro undefined -> out_err=1, out_wen=0, no request.
- Misaligned lw: same access with LSU_MISALIGN_EN defined, words 32'h4433_2211 and 32'h8877_6655 -> two requests, out_data=32'h5544_3322.
- Timeout and reset:
  - TIMEOUT_CYCLES=4, no response -> out_err=1 after 4 RESP cycles.
  - Assert rst during RESP -> all outputs at reset values the next cycle; a late mem_rsp_valid produces no out_valid.
- Backpressure: out_ready low 5 cycles in DONE -> out_valid/out_data held, in_ready=0, new in_valid not accepted.
